// File: rtl/cnn_layer_accel_net_rx_decoder.sv
// Network receive decoder: splits header-framed packets into
// config, weight, pixel and sequencer write strobes.
module cnn_layer_accel_net_rx_decoder #(
    parameter int C_PAYLOAD_WIDTH  = 128,
    parameter int C_SEQ_ADDR_WIDTH = 9,
    parameter int C_LEN_WIDTH      = 16
) (
    input  logic                        network_clk,
    input  logic                        network_rst,
    input  logic                        from_network_valid,
    output logic                        from_network_accept,
    input  logic [C_PAYLOAD_WIDTH-1:0]  from_network_payload,
    input  logic                        pixel_ready,
    output logic [C_PAYLOAD_WIDTH-1:0]  dataout,
    output logic                        config_wren,
    output logic                        weight_wren,
    output logic                        pixel_datain_valid,
    output logic                        seq_wren,
    output logic [C_SEQ_ADDR_WIDTH-1:0] seq_wrAddr,
    output logic                        busy,
    output logic                        bad_opcode
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_DROP
    } state_t;

    localparam logic [3:0] OP_CONFIG = 4'd1;
    localparam logic [3:0] OP_WEIGHT = 4'd2;
    localparam logic [3:0] OP_PIXEL  = 4'd3;
    localparam logic [3:0] OP_SEQ    = 4'd4;

    localparam logic [C_LEN_WIDTH-1:0]      LEN_ONE = 1;
    localparam logic [C_SEQ_ADDR_WIDTH-1:0] SEQ_ONE = 1;

    state_t                      r_state;
    logic [3:0]                  r_op;
    logic [C_LEN_WIDTH-1:0]      r_remaining;
    logic [C_SEQ_ADDR_WIDTH-1:0] r_seq_cnt;
    logic [C_SEQ_ADDR_WIDTH-1:0] r_seq_wrAddr;
    logic [C_PAYLOAD_WIDTH-1:0]  r_dataout;
    logic                        r_config_wren;
    logic                        r_weight_wren;
    logic                        r_pixel_valid;
    logic                        r_seq_wren;
    logic                        r_bad_opcode;

    logic [3:0]             w_hdr_op;
    logic [C_LEN_WIDTH-1:0] w_hdr_len;
    logic                   w_op_valid;
    logic                   w_accept;
    logic                   w_xfer;
    logic                   w_last;

    assign w_hdr_op   = from_network_payload[C_PAYLOAD_WIDTH-1 -: 4];
    assign w_hdr_len  = from_network_payload[C_LEN_WIDTH-1:0];
    assign w_op_valid = (w_hdr_op >= OP_CONFIG) && (w_hdr_op <= OP_SEQ);
    assign w_last     = (r_remaining == LEN_ONE);

    // Only pixel data is back-pressured; reset forces the IDLE view.
    always_comb begin
        w_accept = 1'b1;
        if (r_state == ST_DATA && r_op == OP_PIXEL) begin
            w_accept = pixel_ready;
        end
        if (network_rst) begin
            w_accept = 1'b1;
        end
    end

    assign w_xfer = from_network_valid && w_accept;

    always_ff @(posedge network_clk) begin
        if (network_rst) begin
            r_state       <= ST_IDLE;
            r_op          <= 4'd0;
            r_remaining   <= '0;
            r_seq_cnt     <= '0;
            r_seq_wrAddr  <= '0;
            r_dataout     <= '0;
            r_config_wren <= 1'b0;
            r_weight_wren <= 1'b0;
            r_pixel_valid <= 1'b0;
            r_seq_wren    <= 1'b0;
            r_bad_opcode  <= 1'b0;
        end else begin
            r_config_wren <= 1'b0;
            r_weight_wren <= 1'b0;
            r_pixel_valid <= 1'b0;
            r_seq_wren    <= 1'b0;
            r_bad_opcode  <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        r_bad_opcode <= !w_op_valid;
                        if (w_hdr_op == OP_SEQ) begin
                            r_seq_cnt <= '0;
                        end
                        if (w_hdr_len != '0) begin
                            r_op        <= w_hdr_op;
                            r_remaining <= w_hdr_len;
                            r_state     <= w_op_valid ? ST_DATA : ST_DROP;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_xfer) begin
                        r_dataout   <= from_network_payload;
                        r_remaining <= r_remaining - LEN_ONE;
                        if (w_last) begin
                            r_state <= ST_IDLE;
                        end
                        unique case (r_op)
                            OP_CONFIG: r_config_wren <= 1'b1;
                            OP_WEIGHT: r_weight_wren <= 1'b1;
                            OP_PIXEL:  r_pixel_valid <= 1'b1;
                            OP_SEQ: begin
                                r_seq_wren   <= 1'b1;
                                r_seq_wrAddr <= r_seq_cnt;
                                r_seq_cnt    <= r_seq_cnt + SEQ_ONE;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_DROP: begin
                    if (w_xfer) begin
                        r_remaining <= r_remaining - LEN_ONE;
                        if (w_last) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign from_network_accept = w_accept;
    assign dataout             = r_dataout;
    assign config_wren         = r_config_wren;
    assign weight_wren         = r_weight_wren;
    assign pixel_datain_valid  = r_pixel_valid;
    assign seq_wren            = r_seq_wren;
    assign seq_wrAddr          = r_seq_wrAddr;
    assign busy                = (r_state != ST_IDLE);
    assign bad_opcode          = r_bad_opcode;

endmodule

// File: tb/tb_cnn_layer_accel_net_rx_decoder.sv
// Randomised scoreboard bench for the network receive decoder.
// Expected events come from a packet-level model of the framing rules.
module tb_cnn_layer_accel_net_rx_decoder;

    bit          clk;
    logic        network_rst;
    logic        from_network_valid;
    logic        from_network_accept;
    logic [127:0] from_network_payload;
    logic        pixel_ready;
    logic [127:0] dataout;
    logic        config_wren;
    logic        weight_wren;
    logic        pixel_datain_valid;
    logic        seq_wren;
    logic [8:0]  seq_wrAddr;
    logic        busy;
    logic        bad_opcode;

    int checks = 0;
    int errors = 0;
    bit pr_auto = 1'b1;

    typedef struct {
        int           kind;
        logic [127:0] d;
        logic [8:0]   a;
    } ev_t;

    ev_t q[$];

    bit         m_busy = 1'b0;
    bit         m_drop = 1'b0;
    logic [3:0] m_op = 4'd0;
    int         m_left = 0;
    logic [8:0] m_addr = 9'd0;

    cnn_layer_accel_net_rx_decoder dut (
        .network_clk         (clk),
        .network_rst         (network_rst),
        .from_network_valid  (from_network_valid),
        .from_network_accept (from_network_accept),
        .from_network_payload(from_network_payload),
        .pixel_ready         (pixel_ready),
        .dataout             (dataout),
        .config_wren         (config_wren),
        .weight_wren         (weight_wren),
        .pixel_datain_valid  (pixel_datain_valid),
        .seq_wren            (seq_wren),
        .seq_wrAddr          (seq_wrAddr),
        .busy                (busy),
        .bad_opcode          (bad_opcode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] hdr(input logic [3:0] op,
                                         input logic [15:0] len);
        logic [127:0] d;
        d = rnd128();
        d[127:124] = op;
        d[15:0] = len;
        return d;
    endfunction

    // Packet-level model: one call per transferred beat.
    task automatic model_beat(input logic [127:0] d);
        logic [3:0] op;
        int len;
        ev_t e;
        if (!m_busy) begin
            op = d[127:124];
            len = int'(d[15:0]);
            if (op < 4'd1 || op > 4'd4) begin
                e.kind = 5; e.d = '0; e.a = '0;
                q.push_back(e);
            end
            if (op == 4'd4) m_addr = 9'd0;
            if (len != 0) begin
                m_busy = 1'b1;
                m_op = op;
                m_left = len;
                m_drop = (op < 4'd1 || op > 4'd4);
            end
        end else begin
            if (!m_drop) begin
                e.kind = int'(m_op); e.d = d; e.a = m_addr;
                q.push_back(e);
                if (m_op == 4'd4) m_addr = m_addr + 9'd1;
            end
            m_left--;
            if (m_left == 0) m_busy = 1'b0;
        end
    endtask

    task automatic xfer(input logic [127:0] d);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        from_network_valid = 1'b1;
        from_network_payload = d;
        while (!ok) begin
            @(negedge clk);
            ok = from_network_accept;
            @(posedge clk);
            #1;
            n++;
            if (!ok && n > 200) begin
                checks++;
                errors++;
                $display("FAIL xfer_timeout: no accept after %0d cycles", n);
                break;
            end
        end
        if (ok) model_beat(d);
        from_network_valid = 1'b0;
        from_network_payload = rnd128();
    endtask

    task automatic idle(input int n);
        from_network_valid = 1'b0;
        repeat (n) begin
            from_network_payload = rnd128();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_dataout"}, dataout, '0);
        chk({tag, "_strobes"},
            {config_wren, weight_wren, pixel_datain_valid, seq_wren}, '0);
        chk({tag, "_addr"}, seq_wrAddr, '0);
        chk({tag, "_busy"}, busy, '0);
        chk({tag, "_bad"}, bad_opcode, '0);
        chk({tag, "_accept"}, from_network_accept, 1);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (pr_auto) pixel_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin : mon
        int n;
        int k;
        ev_t e;
        logic ea;
        ea = network_rst || !m_busy || m_drop || (m_op != 4'd3) ||
             pixel_ready;
        chk("accept", from_network_accept, ea);
        if (!network_rst) chk("busy", busy, m_busy);
        n = int'(config_wren) + int'(weight_wren) +
            int'(pixel_datain_valid) + int'(seq_wren) + int'(bad_opcode);
        k = config_wren ? 1 : weight_wren ? 2 : pixel_datain_valid ? 3 :
            seq_wren ? 4 : 5;
        if (n > 1) begin
            checks++;
            errors++;
            $display("FAIL onehot: %0d strobes high", n);
        end else if (n == 1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected: kind %0d with none pending", k);
            end else begin
                e = q.pop_front();
                chk("kind", k, e.kind);
                if (k != 5) chk("dataout", dataout, e.d);
                if (k == 4) chk("seq_addr", seq_wrAddr, e.a);
            end
        end
    end

    initial begin
        logic [3:0] op;
        int len;
        logic [127:0] w;
        network_rst = 1'b1;
        from_network_valid = 1'b0;
        from_network_payload = '0;
        pixel_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        network_rst = 1'b0;
        idle(2);

        // Config, three back-to-back beats
        xfer(hdr(4'd1, 16'd3));
        xfer(rnd128());
        xfer(rnd128());
        xfer(rnd128());
        idle(2);

        // Pixel packet stalled by pixel_ready
        pr_auto = 1'b0;
        pixel_ready = 1'b0;
        xfer(hdr(4'd3, 16'd2));
        w = rnd128();
        from_network_valid = 1'b1;
        from_network_payload = w;
        repeat (4) begin
            @(negedge clk);
            chk("stall_accept", from_network_accept, 0);
            @(posedge clk);
            #1;
        end
        pixel_ready = 1'b1;
        xfer(w);
        xfer(rnd128());
        pr_auto = 1'b1;
        idle(2);

        // Long sequencer packet wraps the address, then restarts
        xfer(hdr(4'd4, 16'd514));
        for (int i = 0; i < 514; i++) xfer(rnd128());
        xfer(hdr(4'd4, 16'd2));
        xfer(rnd128());
        xfer(rnd128());
        idle(2);

        // Invalid opcode dropped, then weight
        xfer(hdr(4'd7, 16'd2));
        xfer(rnd128());
        xfer(rnd128());
        xfer(hdr(4'd2, 16'd1));
        xfer(rnd128());
        xfer(hdr(4'd9, 16'd0));
        idle(2);

        // Reset mid-packet
        xfer(hdr(4'd2, 16'd3));
        xfer(rnd128());
        network_rst = 1'b1;
        m_busy = 1'b0;
        m_drop = 1'b0;
        m_addr = 9'd0;
        @(posedge clk);
        #1;
        network_rst = 1'b0;
        @(negedge clk);
        check_zero("midrst");
        @(posedge clk);
        #1;
        xfer(hdr(4'd4, 16'd1));
        xfer(rnd128());
        idle(2);

        // Random packets, gaps and back-pressure
        for (int p = 0; p < 80; p++) begin
            k_pick: begin
                int r;
                r = int'($urandom_range(0, 9));
                if (r < 8) op = 4'(1 + r % 4);
                else if (r == 8) op = 4'd0;
                else op = 4'($urandom_range(5, 15));
            end
            len = int'($urandom_range(0, 5));
            xfer(hdr(op, 16'(len)));
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
                xfer(rnd128());
            end
            if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(0, 2)));
        end

        idle(5);
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/cnn_layer_accel_net_rx_decoder.md
CNN_LAYER_ACCEL_NET_RX_DECODER -- requirements
Module: cnn_layer_accel_net_rx_decoder

Interface
REQ-001 The block SHALL have these parameters:
- C_PAYLOAD_WIDTH, 128, network payload width in bits.
- C_SEQ_ADDR_WIDTH, 9, sequencer BRAM write-address width.
- C_LEN_WIDTH, 16, header beat-count width.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- network_clk  in  1  sole clock; all state changes on the rising edge.
- network_rst  in  1  synchronous, active-high reset.
- from_network_valid  in  1  upstream beat valid.
- from_network_accept  out  1  block accepts the current beat.
- from_network_payload  in  C_PAYLOAD_WIDTH  upstream beat data.
- pixel_ready  in  1  downstream can take a pixel beat this cycle.
- dataout  out  C_PAYLOAD_WIDTH  registered copy of the last accepted data beat.
- config_wren  out  1  one-cycle strobe: dataout is a config word.
- weight_wren  out  1  one-cycle strobe: dataout is a weight word.
- pixel_datain_valid  out  1  one-cycle strobe: dataout is a pixel word.
- seq_wren  out  1  one-cycle strobe: dataout is a sequencer word.
- seq_wrAddr  out  C_SEQ_ADDR_WIDTH  sequencer write address, valid with seq_wren.
- busy  out  1  high whenever state is not IDLE.
- bad_opcode  out  1  one-cycle pulse on an unknown header opcode.

Function
REQ-003 A beat SHALL transfer only in a cycle where from_network_valid and from_network_accept are both 1.

REQ-004 Packet format SHALL be one header beat followed by LEN data beats.
- Opcode: from_network_payload[C_PAYLOAD_WIDTH-1 -: 4].
- LEN: from_network_payload[C_LEN_WIDTH-1:0].
- All other header bits are ignored.

REQ-005 Opcodes SHALL be: 1 = CONFIG, 2 = WEIGHT, 3 = PIXEL, 4 = SEQ. Every other value is invalid.

REQ-006 States SHALL be IDLE, DATA and DROP.

REQ-007 Header transfer in IDLE:
- valid opcode, LEN > 0: latch opcode, load remaining = LEN, go to DATA.
- any opcode, LEN = 0: stay in IDLE, no strobes.
- invalid opcode, LEN > 0: go to DROP, load remaining = LEN.

REQ-008 bad_opcode SHALL pulse for exactly one cycle, the cycle after any invalid-opcode header transfer, including LEN = 0.

REQ-009 Each beat transfer in DATA or DROP SHALL decrement remaining by 1. A transfer with remaining = 1 SHALL return the state to IDLE.

REQ-010 from_network_accept SHALL be combinational from state and pixel_ready:
- 1 in IDLE and DROP.
- 1 in DATA for CONFIG, WEIGHT and SEQ packets.
- equal to pixel_ready in DATA for PIXEL packets.

REQ-011 Each DATA-state beat transfer SHALL, on the next cycle:
- load dataout with the beat payload;
- assert exactly one strobe (config_wren, weight_wren, pixel_datain_valid or seq_wren, per opcode) for one cycle.

Latency from transfer to strobe is 1 cycle.

REQ-012 DROP-state transfers SHALL produce no strobe and SHALL leave dataout unchanged.

REQ-013 Sequencer addressing:
- A SEQ header transfer SHALL clear the sequencer address counter to 0.
- Each SEQ data transfer SHALL present the counter value on seq_wrAddr alongside seq_wren, then increment the counter.
- The counter SHALL wrap from 2^C_SEQ_ADDR_WIDTH-1 to 0 with no error indication.

REQ-014 seq_wrAddr SHALL hold its value while seq_wren is 0.

REQ-015 Back-to-back packets SHALL be supported: the header of packet N+1 may transfer in the cycle after the last data beat of packet N (the first IDLE cycle).

REQ-016 from_network_payload SHALL be ignored whenever from_network_valid is 0.

Reset
REQ-017 Synchronous reset (network_rst = 1 at a clock edge) SHALL set:
- state = IDLE;
- remaining = 0;
- sequencer address counter = 0;
- dataout = 0;
- all strobes, seq_wrAddr, busy and bad_opcode = 0.

REQ-018 Reset asserted mid-packet SHALL abandon the packet. The next accepted beat after reset SHALL be decoded as a header.

REQ-019 from_network_accept SHALL be 1 during reset, consistent with the IDLE state.

Verification
REQ-020 CONFIG header with LEN = 3, then beats A, B, C back-to-back -> config_wren high for 3 consecutive cycles, each 1 cycle after its transfer; dataout = A, B, C in order; busy falls after C.

REQ-021 PIXEL header with LEN = 2, pixel_ready = 0 for 4 cycles, then 1 -> from_network_accept = 0 for those 4 cycles; no pixel_datain_valid during them; then 2 strobes.

REQ-022 SEQ header with LEN = 514 -> seq_wrAddr sequence 0..511, 0, 1; exactly 514 seq_wren pulses; a second SEQ packet restarts at address 0.

REQ-023 Header with opcode 7 and LEN = 2, followed by a WEIGHT header with LEN = 1 and beat W -> bad_opcode pulses once; 2 beats are dropped silently; then a single weight_wren with dataout = W.

REQ-024 network_rst pulsed after 1 of 3 WEIGHT data beats -> all outputs are 0 the cycle after reset; the next beat (opcode 4, LEN = 1) is decoded as a SEQ header; the beat after it produces seq_wren with seq_wrAddr = 0.
